serial_add_sequencer: RTL and testbench

Control wrapper around the 16-bit bit-serial adder datapath: accepts a pair of 16-bit operands on a start request, runs the load/shift sequence for exactly 16 bit-cycles, and presents the registered sum and carry with a one-cycle done pulse. It sits between a parallel-word requester and the serial datapath (two 16-bit right-shifting operand registers, carry-hold flop, 1-bit full adder, 16-bit sum shift register). It owns all load, shift and clear sequencing so the requester never drives datapath control directly.

---
 rtl/serial_add_sequencer.sv | 91 +++++++++
 tb/tb_serial_add_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Sequencer and datapath for a 16-bit bit-serial adder: it loads the operands, runs 16 shift
// cycles and registers the sum and carry. Define SERIAL_ADD_SUB_EN to enable subtract via `sub`.
module serial_add_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [3:0]  count_q;
  logic [15:0] op_a_q;
  logic [15:0] op_b_q;
  logic [15:0] sum_sr_q;
  logic        carry_q;

  logic        fa_sum;
  logic        fa_carry;
  logic [15:0] load_b;
  logic        load_cin;

  assign fa_sum   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign fa_carry = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: a + ~b + 1.
  assign load_b   = sub ? ~b : b;
  assign load_cin = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign load_b     = b;
  assign load_cin   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= 4'd0;
      op_a_q   <= 16'h0000;
      op_b_q   <= 16'h0000;
      sum_sr_q <= 16'h0000;
      carry_q  <= 1'b0;
      sum      <= 16'h0000;
      cout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= load_b;
            carry_q <= load_cin;
            count_q <= 4'd0;
            busy    <= 1'b1;
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          sum_sr_q <= {fa_sum, sum_sr_q[15:1]};
          carry_q  <= fa_carry;
          op_a_q   <= {1'b0, op_a_q[15:1]};
          op_b_q   <= {1'b0, op_b_q[15:1]};
          count_q  <= count_q + 4'd1;
          // Sixteenth shift: the assembled word is published directly, bypassing sum_sr_q.
          if (count_q == 4'd15) begin
            sum     <= {fa_sum, sum_sr_q[15:1]};
            cout    <= fa_carry;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: directed cases from the test plan plus random
// operations compared against an arithmetic reference model.
module tb_serial_add_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_sum;
  logic        last_cout;

  serial_add_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                       output logic [15:0] s, output logic c);
    int unsigned r;
`ifdef SERIAL_ADD_SUB_EN
    if (msub) begin
      s = 16'(int'(ma) - int'(mb));
      c = (ma >= mb);
      return;
    end
`endif
    r = int'(ma) + int'(mb);
    s = r[15:0];
    c = r[16];
  endtask

  // Expects the accepting edge to have just passed. Observes 16 busy cycles, then the done
  // cycle. A one-cycle start pulse is injected at cycle `glitch` when it is non-negative.
  task automatic shift_phase(input logic [15:0] es, input logic ec, input int glitch);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("busy_in_shift", 32'(busy), 32'd1);
      check("no_done_in_shift", 32'(done), 32'd0);
      check("sum_held", 32'({cout, sum}), 32'({last_cout, last_sum}));
      if (i == glitch) start = 1'b1;
      else if (glitch >= 0 && i == glitch + 1) start = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_low_done", 32'(busy), 32'd0);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
    last_sum  = es;
    last_cout = ec;
  endtask

  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic osub);
    logic [15:0] es;
    logic        ec;
    model(oa, ob, osub, es, ec);
    @(negedge clk);
    a = oa; b = ob; sub = osub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    shift_phase(es, ec, -1);
  endtask

  initial begin
    logic [15:0] es;
    logic        ec;
    reset = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0;
    last_sum = 16'h0000; last_cout = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0);
    check("plan_5555", 32'({cout, sum}), 32'h0_5555);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    check("plan_wrap", 32'({cout, sum}), 32'h1_0000);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    check("plan_fffe", 32'({cout, sum}), 32'h1_FFFE);
    @(negedge clk);
    check("idle_after_done", 32'({busy, done}), 32'd0);

    // Back-to-back with start held high, plus a start glitch during the second sequence.
    a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h8000; b = 16'h8000;
    shift_phase(16'h0003, 1'b0, -1);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'h1111; b = 16'h2222;
    shift_phase(16'h0000, 1'b1, 6);
    @(negedge clk);
    check("no_extra_done", 32'({busy, done}), 32'd0);
    repeat (18) begin
      @(negedge clk);
      check("stay_idle", 32'({busy, done}), 32'd0);
    end

    // Subtract/ignored-sub cases.
    run_op(16'h0005, 16'h0007, 1'b1);
    run_op(16'h0007, 16'h0005, 1'b1);
`ifndef SERIAL_ADD_SUB_EN
    check("sub_ignored", 32'({cout, sum}), 32'h0_000C);
`endif

    // Random operations.
    for (int n = 0; n < 24; n++) run_op(16'($urandom), 16'($urandom), 1'($urandom));

    // Reset aborts a sequence mid-shift.
    run_op(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'({cout, sum}), 32'd0);
    last_sum = 16'h0000; last_cout = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("abort_no_done", 32'({busy, done}), 32'd0);
    end
    run_op(16'h0002, 16'h0003, 1'b0);
    check("after_abort", 32'({cout, sum}), 32'h0_0005);
    model(16'h0002, 16'h0003, 1'b0, es, ec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
